// File: rtl/zs_pkg.sv
// Shared definitions for the zero-skipping brick scheduler.
package zs_pkg;

  localparam int unsigned NDefault        = 16;
  localparam int unsigned BrickDefault    = 16;
  localparam int unsigned OffsetSzDefault = 4;

  // Widest mask the one-hot helper can test; BRICK must not exceed this.
  localparam int unsigned MaskMaxW = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StEmpty = 2'd2
  } zs_state_e;

  // True when at most one bit is still set, i.e. the current beat is the last.
  function automatic logic one_hot_rem(input logic [MaskMaxW-1:0] mask);
    return (mask & (mask - MaskMaxW'(1))) == '0;
  endfunction

endpackage

// File: rtl/zs_lsb_penc.sv
// Lowest-set-bit priority encoder over a BRICK-wide request vector.
module zs_lsb_penc #(
  parameter int unsigned BRICK = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [BRICK-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan high to low so the lowest set bit wins the final assignment.
  always_comb begin
    idx = '0;
    for (int k = int'(BRICK) - 1; k >= 0; k--) begin
      if (req[k]) idx = IDX_W'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/zs_brick_sched.sv
// Zero-skipping scheduler: accepts a brick, emits its non-zero entries in
// ascending offset order, or a single empty marker beat for an all-zero brick.
module zs_brick_sched
  import zs_pkg::*;
#(
  parameter int unsigned N         = NDefault,
  parameter int unsigned BRICK     = BrickDefault,
  parameter int unsigned OFFSET_SZ = OffsetSzDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [BRICK*N-1:0]   i_brick,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N-1:0]         o_data,
  output logic [OFFSET_SZ-1:0] o_offset,
  output logic [OFFSET_SZ:0]   o_count,
  output logic                 o_last,
  output logic                 o_empty
);

  localparam logic [OFFSET_SZ:0] CntOne = 1;

  zs_state_e              state_q, state_d;
  logic [BRICK*N-1:0]     brick_q, brick_d;
  logic [BRICK-1:0]       mask_q, mask_d;
  logic [OFFSET_SZ:0]     count_q, count_d;

  logic [BRICK-1:0]       new_mask;
  logic [OFFSET_SZ-1:0]   sel;
  logic                   sel_any;
  logic                   last_beat;

  // Per-entry non-zero flags of the incoming brick.
  always_comb begin
    new_mask = '0;
    for (int k = 0; k < int'(BRICK); k++) begin
      new_mask[k] = |i_brick[k*N +: N];
    end
  end

  zs_lsb_penc #(
    .BRICK (BRICK),
    .IDX_W (OFFSET_SZ)
  ) u_penc (
    .req (mask_q),
    .idx (sel),
    .any (sel_any)
  );

  assign last_beat = one_hot_rem(MaskMaxW'(mask_q));

  // State, brick, mask and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      brick_q <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      brick_q <= brick_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  // Next-state and output decode; outputs depend only on registered state,
  // so they hold steady while a beat is stalled.
  always_comb begin
    state_d  = state_q;
    brick_d  = brick_q;
    mask_d   = mask_q;
    count_d  = count_q;
    i_ready  = 1'b0;
    o_valid  = 1'b0;
    o_data   = '0;
    o_offset = '0;
    o_count  = '0;
    o_last   = 1'b0;
    o_empty  = 1'b0;

    unique case (state_q)
      StIdle: begin
        i_ready = 1'b1;
        if (i_valid) begin
          brick_d = i_brick;
          mask_d  = new_mask;
          count_d = '0;
          state_d = (|new_mask) ? StScan : StEmpty;
        end
      end

      StScan: begin
        o_valid  = sel_any;
        o_data   = brick_q[sel*N +: N];
        o_offset = sel;
        o_count  = count_q + CntOne;
        o_last   = last_beat;
        if (o_ready && sel_any) begin
          mask_d[sel] = 1'b0;
          count_d     = count_q + CntOne;
          if (last_beat) state_d = StIdle;
        end
      end

      StEmpty: begin
        o_valid = 1'b1;
        o_empty = 1'b1;
        o_last  = 1'b1;
        if (o_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_zs_brick_sched.sv
// Self-checking bench for zs_brick_sched: a beat-queue model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_zs_brick_sched;

  localparam int unsigned N     = 16;
  localparam int unsigned BRICK = 16;
  localparam int unsigned OW    = 4;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              i_ready;
  logic [BRICK*N-1:0] i_brick;
  logic              o_valid;
  logic              o_ready;
  logic [N-1:0]      o_data;
  logic [OW-1:0]     o_offset;
  logic [OW:0]       o_count;
  logic              o_last;
  logic              o_empty;

  zs_brick_sched #(
    .N         (N),
    .BRICK     (BRICK),
    .OFFSET_SZ (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_brick  (i_brick),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_offset (o_offset),
    .o_count  (o_count),
    .o_last   (o_last),
    .o_empty  (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;
  int hs_cnt   = 0;
  int last_cnt = 0;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [OW-1:0] off;
    logic [OW:0]   cnt;
    logic          last;
    logic          empty;
  } beat_t;

  beat_t exp_q[$];

  // Expected beat list of a brick: non-zeros in ascending offset, or one marker.
  function automatic void load_brick(input logic [BRICK*N-1:0] b);
    int nz;
    int c;
    beat_t bt;
    nz = 0;
    for (int k = 0; k < int'(BRICK); k++) if (b[k*N +: N] != 0) nz++;
    if (nz == 0) begin
      bt = '{data: '0, off: '0, cnt: '0, last: 1'b1, empty: 1'b1};
      exp_q.push_back(bt);
    end else begin
      c = 0;
      for (int k = 0; k < int'(BRICK); k++) begin
        if (b[k*N +: N] != 0) begin
          c++;
          bt.data  = b[k*N +: N];
          bt.off   = OW'(k);
          bt.cnt   = (OW+1)'(c);
          bt.last  = (c == nz);
          bt.empty = 1'b0;
          exp_q.push_back(bt);
        end
      end
    end
  endfunction

  // Model: a brick is taken only when no beats are pending; a beat retires on o_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() != 0) begin
      if (o_ready) void'(exp_q.pop_front());
    end else if (i_valid) begin
      load_brick(i_brick);
    end
  end

  // Handshake counters used by the literal checks.
  always @(posedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      hs_cnt++;
      if (o_last) last_cnt++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic [28:0] exp_v;
    logic [28:0] act_v;
    beat_t b;
    if (chk_on) begin
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        exp_v = {1'b1, 1'b0, b.data, b.off, b.cnt, b.last, b.empty};
      end else begin
        exp_v = {1'b0, 1'b1, 27'd0};
      end
      act_v = {o_valid, i_ready, o_data, o_offset, o_count, o_last, o_empty};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got v/rdy/data/off/cnt/last/empty=%h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic [N-1:0] d, input logic [OW-1:0] off,
                          input logic [OW:0] cnt, input logic last);
    chk({name, "_valid"},  32'(o_valid),  32'd1);
    chk({name, "_data"},   32'(o_data),   32'(d));
    chk({name, "_offset"}, 32'(o_offset), 32'(off));
    chk({name, "_count"},  32'(o_count),  32'(cnt));
    chk({name, "_last"},   32'(o_last),   32'(last));
  endtask

  // Present a brick and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [BRICK*N-1:0] b);
    logic acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    i_brick = b;
    i_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
    end
    #1;
    i_valid = 1'b0;
    i_brick = '1;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout t=%0t got i_ready=0 want 1", $time);
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = i_ready;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout t=%0t got i_ready=0 want 1", $time);
    end
  endtask

  logic [BRICK*N-1:0] sparse, dense, sparse2, other;
  int hs0, last0;

  initial begin
    sparse = '0;
    sparse[0*N +: N]  = 16'h0011;
    sparse[5*N +: N]  = 16'h8000;
    sparse[15*N +: N] = 16'h0001;
    dense = '0;
    for (int k = 0; k < int'(BRICK); k++) dense[k*N +: N] = N'(k + 1);
    sparse2 = '0;
    sparse2[3*N +: N] = 16'h00A0;
    sparse2[9*N +: N] = 16'h0001;
    other = '0;
    other[1*N +: N] = 16'h1234;

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_brick = '0;
    o_ready = 1'b1;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_outs", {o_data, 4'(o_offset), 3'd0, o_count, o_last, o_empty}, 32'd0);
    chk_on = 1'b1;

    // Sparse brick.
    hs0 = hs_cnt;
    send(sparse);
    @(negedge clk); chk_beat("sp_b1", 16'h0011, 4'd0, 5'd1, 1'b0);
    chk("sp_busy_i_ready", 32'(i_ready), 32'd0);
    @(negedge clk); chk_beat("sp_b2", 16'h8000, 4'd5, 5'd2, 1'b0);
    @(negedge clk); chk_beat("sp_b3", 16'h0001, 4'd15, 5'd3, 1'b1);
    @(negedge clk);
    chk("sp_ready_back", 32'(i_ready), 32'd1);
    chk("sp_valid_off", 32'(o_valid), 32'd0);
    chk("sp_beats", 32'(hs_cnt - hs0), 32'd3);

    // All-zero brick.
    send('0);
    @(negedge clk);
    chk("emp_valid", 32'(o_valid), 32'd1);
    chk("emp_flags", {30'd0, o_empty, o_last}, 32'd3);
    chk("emp_data_cnt", {11'd0, o_count, o_data}, 32'd0);
    @(negedge clk);
    chk("emp_ready_back", 32'(i_ready), 32'd1);

    // Dense brick.
    hs0 = hs_cnt;
    last0 = last_cnt;
    send(dense);
    wait_idle();
    chk("dense_beats", 32'(hs_cnt - hs0), 32'd16);
    chk("dense_lasts", 32'(last_cnt - last0), 32'd1);

    // Backpressure on second beat, with an upstream pulse during SCAN.
    hs0 = hs_cnt;
    send(sparse);
    @(negedge clk); chk_beat("bp_b1", 16'h0011, 4'd0, 5'd1, 1'b0);
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_brick = other;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_beat("bp_hold", 16'h8000, 4'd5, 5'd2, 1'b0);
    end
    o_ready = 1'b1;
    i_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("bp_beats", 32'(hs_cnt - hs0), 32'd3);
    chk("bp_no_extra", 32'(o_valid), 32'd0);

    // Reset in the middle of a dense brick.
    hs0 = hs_cnt;
    last0 = last_cnt;
    send(dense);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_ready", 32'(i_ready), 32'd1);
    chk("mid_rst_beats", 32'(hs_cnt - hs0), 32'd3);
    chk("mid_rst_nolast", 32'(last_cnt - last0), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(sparse2);
    @(negedge clk); chk_beat("post_b1", 16'h00A0, 4'd3, 5'd1, 1'b0);
    @(negedge clk); chk_beat("post_b2", 16'h0001, 4'd9, 5'd2, 1'b1);
    wait_idle();

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
